// File: rtl/cpu_pkg.sv
// cpu_pkg: shared state, cause codes, PS bit positions and default vectors for the interrupt sequencer.
package cpu_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_RESET, S_PUSH_PCH, S_PUSH_PCL, S_PUSH_PS, S_VEC_LO, S_VEC_HI, S_LOAD_PC
  } state_t;
  typedef enum logic [1:0] {C_RST, C_NMI, C_IRQ, C_BRK} cause_t;
  localparam int PS_I = 2;
  localparam int PS_B = 4;
  localparam int PS_U = 5;
  localparam logic [15:0] VEC_NMI_DEF = 16'hFFFA;
  localparam logic [15:0] VEC_RST_DEF = 16'hFFFC;
  localparam logic [15:0] VEC_IRQ_DEF = 16'hFFFE;
  localparam logic [7:0]  STACK_PAGE_DEF = 8'h01;
endpackage

// File: rtl/cpu_nmi_latch.sv
// cpu_nmi_latch: rising-edge detector on nmi with a pending flag; a new edge wins over a same-cycle clear.
module cpu_nmi_latch (
  input  logic clk,
  input  logic reset,
  input  logic i_nmi,
  input  logic i_clr,
  output logic o_pend
);
  logic r_nmi_q, r_pend;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_nmi_q <= 1'b0;
      r_pend  <= 1'b0;
    end else begin
      r_nmi_q <= i_nmi;
      r_pend  <= (i_nmi & ~r_nmi_q) | (r_pend & ~i_clr);
    end
  assign o_pend = r_pend;
endmodule

// File: rtl/cpu_irq_sequencer.sv
// cpu_irq_sequencer: drives stack pushes, vector fetch and PC load for RESET/NMI/IRQ/BRK entry.
module cpu_irq_sequencer
  import cpu_pkg::*;
#(
  parameter logic [15:0] VEC_NMI    = VEC_NMI_DEF,
  parameter logic [15:0] VEC_RST    = VEC_RST_DEF,
  parameter logic [15:0] VEC_IRQ    = VEC_IRQ_DEF,
  parameter logic [7:0]  STACK_PAGE = STACK_PAGE_DEF,
  parameter bit          RST_FETCH  = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        nmi,
  input  logic        irq,
  input  logic        brk_req,
  input  logic        insn_boundary,
  input  logic [15:0] pc,
  input  logic [7:0]  sp,
  input  logic [7:0]  ps,
  input  logic [7:0]  mem_rdata,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  output logic [7:0]  data_out,
  output logic [15:0] pc_out,
  output logic        we_sp,
  output logic        we_ps,
  output logic        we_pc,
  output logic        seq_busy,
  output logic        seq_done,
  output logic [1:0]  seq_cause
);
  state_t      r_state;
  cause_t      r_cause;
  logic [15:0] r_vec, r_pc, r_addr;
  logic [7:0]  r_vec_lo, r_sp, r_ps, r_wdata, r_data;
  logic        r_mem_we, r_mem_re, r_we_sp, r_we_ps, r_we_pc, r_done;
  logic        w_nmi_pend, w_take;
  cause_t      w_cause;
  logic [7:0]  w_sp_dec, w_ps_push;

  cpu_nmi_latch u_nmi (
    .clk    (clk),
    .reset  (reset),
    .i_nmi  (nmi),
    .i_clr  (r_state == S_LOAD_PC && r_cause == C_NMI),
    .o_pend (w_nmi_pend)
  );

  assign w_take   = insn_boundary & (w_nmi_pend | brk_req | (irq & ~ps[PS_I]));
  assign w_cause  = w_nmi_pend ? C_NMI : brk_req ? C_BRK : C_IRQ;
  assign w_sp_dec = r_sp - 8'd1;

  always_comb begin
    w_ps_push       = r_ps;
    w_ps_push[PS_U] = 1'b1;
    w_ps_push[PS_B] = r_cause == C_BRK;
  end

  // r_sp tracks the stack pointer the register file will hold in the current push cycle
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state  <= RST_FETCH ? S_RESET : S_IDLE;
      r_cause  <= C_RST;
      r_vec    <= '0;
      r_vec_lo <= '0;
      r_pc     <= '0;
      r_sp     <= '0;
      r_ps     <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_data   <= '0;
      r_mem_we <= 1'b0;
      r_mem_re <= 1'b0;
      r_we_sp  <= 1'b0;
      r_we_ps  <= 1'b0;
      r_we_pc  <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_mem_we <= 1'b0;
      r_mem_re <= 1'b0;
      r_we_sp  <= 1'b0;
      r_we_ps  <= 1'b0;
      r_we_pc  <= 1'b0;
      r_done   <= 1'b0;
      case (r_state)
        S_IDLE: if (w_take) begin
          r_state  <= S_PUSH_PCH;
          r_cause  <= w_cause;
          r_vec    <= w_cause == C_NMI ? VEC_NMI : VEC_IRQ;
          r_pc     <= pc;
          r_ps     <= ps;
          r_sp     <= sp - 8'd1;
          r_addr   <= {STACK_PAGE, sp};
          r_wdata  <= pc[15:8];
          r_data   <= sp - 8'd1;
          r_mem_we <= 1'b1;
          r_we_sp  <= 1'b1;
        end
        S_PUSH_PCH, S_PUSH_PCL: begin
          r_state  <= r_state == S_PUSH_PCH ? S_PUSH_PCL : S_PUSH_PS;
          r_addr   <= {STACK_PAGE, r_sp};
          r_wdata  <= r_state == S_PUSH_PCH ? r_pc[7:0] : w_ps_push;
          r_data   <= w_sp_dec;
          r_sp     <= w_sp_dec;
          r_mem_we <= 1'b1;
          r_we_sp  <= 1'b1;
        end
        S_PUSH_PS, S_RESET: begin
          r_state  <= S_VEC_LO;
          r_vec    <= r_state == S_RESET ? VEC_RST : r_vec;
          r_addr   <= r_state == S_RESET ? VEC_RST : r_vec;
          r_data   <= (r_state == S_RESET ? ps : r_ps) | (8'h1 << PS_I);
          r_mem_re <= 1'b1;
          r_we_ps  <= 1'b1;
        end
        S_VEC_LO: begin
          r_state  <= S_VEC_HI;
          r_addr   <= r_vec + 16'd1;
          r_mem_re <= 1'b1;
        end
        S_VEC_HI: begin
          r_state  <= S_LOAD_PC;
          r_vec_lo <= mem_rdata;
          r_we_pc  <= 1'b1;
          r_done   <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end

  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_we    = r_mem_we;
  assign mem_re    = r_mem_re;
  assign data_out  = r_data;
  assign pc_out    = {mem_rdata, r_vec_lo};
  assign we_sp     = r_we_sp;
  assign we_ps     = r_we_ps;
  assign we_pc     = r_we_pc;
  assign seq_busy  = r_state != S_IDLE;
  assign seq_done  = r_done;
  assign seq_cause = r_cause;
endmodule
